// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1 UART transmitter, one byte per vld_tx/rdy_tx handshake.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       vld_tx,
   output logic       rdy_tx,
   output logic       txd,
   output logic       busy,
   output logic       tx_done
);

   localparam int            TW          = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] LP_BIT_LAST = TW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t        r_state, w_state_nxt;
   logic [TW-1:0] r_timer, w_timer_nxt;
   logic [2:0]    r_idx,   w_idx_nxt;
   logic [7:0]    r_shreg, w_shreg_nxt;
   logic          r_txd,   w_txd_nxt;
   logic          r_rdy,   w_rdy_nxt;
   logic          r_busy,  w_busy_nxt;
   logic          r_done,  w_done_nxt;
   logic          w_bit_end;
`ifdef UART_TX_PARITY_EN
   logic          r_par,   w_par_nxt;
`endif

   assign w_bit_end = (r_timer == LP_BIT_LAST);

   // NOTE: every flop, shift register included, takes the async reset so an
   // aborted frame leaves no stale state and txd snaps straight back to idle-high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_idx   <= '0;
         r_shreg <= '0;
         r_txd   <= 1'b1;
         r_rdy   <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_idx   <= w_idx_nxt;
         r_shreg <= w_shreg_nxt;
         r_txd   <= w_txd_nxt;
         r_rdy   <= w_rdy_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   always_comb begin
      // NOTE: hold-value defaults first keep this block free of latches.
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_idx_nxt   = r_idx;
      w_shreg_nxt = r_shreg;
      w_txd_nxt   = r_txd;
      w_rdy_nxt   = r_rdy;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = r_par;
`endif

      if (r_state != S_IDLE) begin
         w_timer_nxt = w_bit_end ? '0 : r_timer + TW'(1);
      end

      // Each branch sets the line level for the *next* bit, so txd stays a pure flop.
      case (r_state)
         S_IDLE: begin
            if (vld_tx) begin
               w_state_nxt = S_START;
               w_shreg_nxt = din;
               w_timer_nxt = '0;
               w_idx_nxt   = '0;
               w_txd_nxt   = 1'b0;
               w_rdy_nxt   = 1'b0;
               w_busy_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
               w_par_nxt   = ^din;
`endif
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_nxt = S_DATA;
               w_txd_nxt   = r_shreg[0];
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
                  w_txd_nxt   = r_par;
`else
                  w_state_nxt = S_STOP;
                  w_txd_nxt   = 1'b1;
`endif
               end else begin
                  w_idx_nxt   = r_idx + 3'd1;
                  w_shreg_nxt = {1'b0, r_shreg[7:1]};
                  w_txd_nxt   = r_shreg[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt = S_STOP;
               w_txd_nxt   = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (w_bit_end) begin
               w_state_nxt = S_IDLE;
               w_rdy_nxt   = 1'b1;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
            w_rdy_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign rdy_tx  = r_rdy;
   assign txd     = r_txd;
   assign busy    = r_busy;
   assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: table-driven frames decoded by a line
// monitor against a scoreboard, plus hand sequences for reset abort and N=2.
`timescale 1ns/1ps
module tb_uart_tx_frame;

   localparam int N  = 4;
   localparam int N2 = 2;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   typedef struct { logic [7:0] d; logic par; } vec_t;
   typedef struct { logic [7:0] d; logic par; int acc; } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din_a, din_b;
   logic       vld_a, vld_b;
   logic       rdy_a, txd_a, busy_a, done_a;
   logic       rdy_b, txd_b, busy_b, done_b;

   uart_tx_frame #(.CLKS_PER_BIT(N)) dut_a (
      .clk(clk), .rst(rst), .din(din_a), .vld_tx(vld_a),
      .rdy_tx(rdy_a), .txd(txd_a), .busy(busy_a), .tx_done(done_a));

   uart_tx_frame #(.CLKS_PER_BIT(N2)) dut_b (
      .clk(clk), .rst(rst), .din(din_b), .vld_tx(vld_b),
      .rdy_tx(rdy_b), .txd(txd_b), .busy(busy_b), .tx_done(done_b));

   always #5 clk = ~clk;

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_vec = 0;
   int   n_err = 0;
   int   n_done = 0;
   int   n_sent = 0;
   logic mon_en = 1'b0;
   logic prev_a = 1'b1;
   exp_t sb[$];
   int   starts[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected line levels for one frame: start, data LSB first, [parity], stop.
   function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par);
      logic [10:0] eb;
      eb      = '1;
      eb[0]   = 1'b0;
      eb[8:1] = d;
`ifdef UART_TX_PARITY_EN
      eb[9]   = par;
`else
      if (par === 1'bx) eb[9] = 1'b0;
`endif
      return eb;
   endfunction

   initial begin : done_counter
      forever begin
         @(negedge clk);
         if (done_a === 1'b1) n_done++;
      end
   end

   initial begin : monitor
      exp_t        e;
      logic [10:0] eb;
      logic [7:0]  rx;
      int          k, bad_bit, bad_busy, bad_done;
      forever begin
         @(negedge clk);
         if (mon_en && prev_a === 1'b1 && txd_a === 1'b0) begin
            k = cyc;
            starts.push_back(k);
            if (sb.size() == 0) begin
               check("unexpected_frame", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               eb = frame_bits(e.d, e.par);
               bad_bit = 0; bad_busy = 0; bad_done = 0; rx = '0;
               for (int b = 0; b < NBITS; b++) begin
                  for (int m = 0; m < N; m++) begin
                     if (b != 0 || m != 0) @(negedge clk);
                     if (txd_a !== eb[b]) bad_bit++;
                     if (busy_a !== 1'b1 || rdy_a !== 1'b0) bad_busy++;
                     if (done_a !== 1'b0) bad_done++;
                     if (m == N / 2 && b >= 1 && b <= 8) rx[b-1] = txd_a;
                  end
               end
               check("frame_bits", bad_bit, 0);
               check("busy_rdy_in_frame", bad_busy, 0);
               check("done_early", bad_done, 0);
               check("start_cycle", k, e.acc);
               check("rx_byte", {24'd0, rx}, {24'd0, e.d});
               @(negedge clk);
               check("tx_done_pulse", {31'd0, done_a}, 32'd1);
               check("rdy_after", {31'd0, rdy_a}, 32'd1);
               check("busy_after", {31'd0, busy_a}, 32'd0);
               check("txd_after", {31'd0, txd_a}, 32'd1);
            end
         end
         prev_a = txd_a;
      end
   end

   // Called at a negedge; returns at the negedge just after the accept edge.
   task automatic send_a(input logic [7:0] d, input logic par, input bit keep_vld);
      exp_t e;
      int   t;
      din_a = d;
      vld_a = 1'b1;
      for (t = 0; t < 2000 && rdy_a !== 1'b1; t++) begin
         din_a = 8'($urandom);
         @(negedge clk);
         din_a = d;
      end
      if (t >= 2000) begin
         check("accept_timeout", 32'd0, 32'd1);
         return;
      end
      e.d = d; e.par = par; e.acc = cyc + 1;
      sb.push_back(e);
      n_sent++;
      @(negedge clk);
      if (!keep_vld) vld_a = 1'b0;
      din_a = ~d;
      check("busy_on_accept", {31'd0, busy_a}, 32'd1);
      check("rdy_on_accept", {31'd0, rdy_a}, 32'd0);
   endtask

   task automatic wait_idle();
      int t;
      for (t = 0; t < 2000 && (sb.size() != 0 || rdy_a !== 1'b1); t++) @(negedge clk);
      if (t >= 2000) check("idle_timeout", 32'd0, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t        vt[6];
      logic [10:0] eb;
      int          bad, kb;

      vt[0] = '{8'h07, 1'b1};
      vt[1] = '{8'h55, 1'b0};
      vt[2] = '{8'h00, 1'b0};
      vt[3] = '{8'hFF, 1'b0};
      vt[4] = '{8'h3C, 1'b0};
      vt[5] = '{8'h80, 1'b1};

      rst = 1'b1; vld_a = 1'b0; din_a = '0; vld_b = 1'b0; din_b = '0;
      repeat (3) @(negedge clk);
      check("rst_txd",  {31'd0, txd_a},  32'd1);
      check("rst_rdy",  {31'd0, rdy_a},  32'd1);
      check("rst_busy", {31'd0, busy_a}, 32'd0);
      check("rst_done", {31'd0, done_a}, 32'd0);
      rst = 1'b0;

      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (txd_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || rdy_a !== 1'b1) bad++;
      end
      check("idle_quiet_100", bad, 0);

      mon_en = 1'b1;
      send_a(8'h55, 1'b0, 1'b0);
      wait_idle();
      check("done_count_single", n_done, n_sent);

      // vld_tx held high across two frames; din is scrambled while busy.
      send_a(8'hA3, 1'b0, 1'b1);
      send_a(8'h0F, 1'b0, 1'b0);
      wait_idle();
      if (starts.size() >= 2)
         check("b2b_period", starts[starts.size()-1] - starts[starts.size()-2], NBITS * N + 1);
      else
         check("b2b_frames_seen", starts.size(), 2);

      for (int i = 0; i < 6; i++) send_a(vt[i].d, vt[i].par, i != 5);
      wait_idle();
      check("done_count_table", n_done, n_sent);

      // Reset in the middle of DATA while the line is low.
      mon_en = 1'b0;
      din_a = 8'h00; vld_a = 1'b1;
      @(negedge clk);
      vld_a = 1'b0;
      repeat (N + 2) @(negedge clk);
      check("mid_data_txd_low", {31'd0, txd_a}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("abort_txd",  {31'd0, txd_a},  32'd1);
      check("abort_rdy",  {31'd0, rdy_a},  32'd1);
      check("abort_busy", {31'd0, busy_a}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      send_a(8'hC1, 1'b1, 1'b0);
      wait_idle();
      check("done_count_after_rst", n_done, n_sent);

      // Minimum bit period on the second instance.
      check("b_rdy_idle", {31'd0, rdy_b}, 32'd1);
      din_b = 8'hFF; vld_b = 1'b1;
      @(negedge clk);
      vld_b = 1'b0; din_b = 8'h00;
      kb = cyc;
      eb = frame_bits(8'hFF, 1'b0);
      bad = 0;
      for (int j = 0; j < NBITS * N2; j++) begin
         if (j != 0) @(negedge clk);
         if (txd_b !== eb[j / N2] || busy_b !== 1'b1 || done_b !== 1'b0) bad++;
      end
      check("n2_frame", bad, 0);
      @(negedge clk);
      check("n2_done_cycle", cyc - kb, NBITS * N2);
      check("n2_done", {31'd0, done_b}, 32'd1);
      check("n2_rdy",  {31'd0, rdy_b},  32'd1);
      @(negedge clk);
      check("n2_done_single", {31'd0, done_b}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
